// File: rtl/game_sync_multi.sv
// game_sync_multi: multi-cursor outline painter for a GRID_DIM x GRID_DIM board.
//
// Tracks NUM_CURSORS cursor cells. When a channel's input cell differs from the
// cell currently shown on screen, the channel is serviced: the old outline is
// erased with BG_COLOR and the new one is drawn in the channel colour, as a
// stream of single-pixel writes over a valid/ready port. Channels are served
// one at a time in round-robin order. A cell that is shared by two cursors is
// repaired: when one of them leaves, the other is forced hidden so it is
// redrawn.
//
// Optional build macro: GAME_SYNC_BLINK_EN adds a blink phase that toggles every
// BLINK_PERIOD cycles and repaints every visible cursor on each toggle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cursor_row/col      per-channel cell, 4 bits each, channel c at [4c+3:4c];
//                       a row or column >= GRID_DIM means hidden
//   cursor_color        per-channel outline colour, 3 bits each
//   write_valid/ready   pixel write handshake
//   write_x/y/data      pixel coordinate and colour, zero when not valid
//   busy                high whenever a channel is being serviced

// Per-channel shown position, pending detection and blink request.
module game_sync_lane #(
   parameter int GRID_DIM = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_row,
   input  logic [3:0] in_col,
   input  logic       upd,
   input  logic [3:0] upd_row,
   input  logic [3:0] upd_col,
   input  logic       kill,
   input  logic       blink_set,
   input  logic       blink_clr,
   output logic       pending,
   output logic [3:0] shown_row,
   output logic [3:0] shown_col
);
   localparam logic [3:0] HID = 4'(GRID_DIM);

   logic [3:0] nxt_row, nxt_col;
   logic       pend_q, blink_q;
   logic       in_hid, nxt_hid, cur_hid;

   always_comb begin
      nxt_row = shown_row;
      nxt_col = shown_col;
      if (upd) begin
         nxt_row = upd_row;
         nxt_col = upd_col;
      end else if (kill) begin
         nxt_row = HID;
         nxt_col = HID;
      end
   end

   assign in_hid  = (in_row >= HID) || (in_col >= HID);
   assign nxt_hid = (nxt_row >= HID) || (nxt_col >= HID);
   assign cur_hid = (shown_row >= HID) || (shown_col >= HID);

   // Pending is judged against the position that will be shown after this
   // edge, so the cycle after a service already sees the refreshed state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shown_row <= HID;
         shown_col <= HID;
         pend_q    <= 1'b0;
         blink_q   <= 1'b0;
      end else begin
         shown_row <= nxt_row;
         shown_col <= nxt_col;
         pend_q    <= ((in_row != nxt_row) || (in_col != nxt_col)) && !(in_hid && nxt_hid);
         if (blink_set && !cur_hid)
            blink_q <= 1'b1;
         else if (blink_clr)
            blink_q <= 1'b0;
      end
   end

   assign pending = pend_q | blink_q;
endmodule

module game_sync_multi #(
   parameter int         NUM_CURSORS  = 2,
   parameter int         GRID_DIM     = 9,
   parameter int         CELL_PX      = 8,
   parameter logic [2:0] BG_COLOR     = 3'd0,
   parameter int         BLINK_PERIOD = 25000000,
   localparam int        XW           = $clog2(GRID_DIM*CELL_PX)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CURSORS*4-1:0] cursor_row,
   input  logic [NUM_CURSORS*4-1:0] cursor_col,
   input  logic [NUM_CURSORS*3-1:0] cursor_color,
   output logic                     write_valid,
   input  logic                     write_ready,
   output logic [XW-1:0]            write_x,
   output logic [XW-1:0]            write_y,
   output logic [2:0]               write_data,
   output logic                     busy
);
   localparam int         NC   = NUM_CURSORS;
   localparam int         PW   = (NC > 1) ? $clog2(NC) : 1;
   localparam int         OW   = $clog2(CELL_PX);
   localparam int         WALK = 4*(CELL_PX-1);
   localparam int         SW   = $clog2(WALK);
   localparam logic [3:0] HID  = 4'(GRID_DIM);
   localparam logic [OW-1:0] OMAX = OW'(CELL_PX-1);

   if (NUM_CURSORS < 1 || NUM_CURSORS > 8) begin : g_bad_nc
      $error("NUM_CURSORS must be 1..8");
   end
   if (GRID_DIM < 1 || GRID_DIM > 15) begin : g_bad_grid
      $error("GRID_DIM must fit below the 4-bit hidden code");
   end
   if (CELL_PX < 2) begin : g_bad_cell
      $error("CELL_PX must be at least 2");
   end
   if (BLINK_PERIOD < 1) begin : g_bad_blink
      $error("BLINK_PERIOD must be positive");
   end

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIXUP} state_t;

   state_t state, state_n;

   logic [NC-1:0][3:0] in_row, in_col, shown_row, shown_col;
   logic [NC-1:0][2:0] in_clr;
   logic [NC-1:0]      pend, upd, kill, blink_set, blink_clr;

   logic [PW-1:0] ptr, sel, sel_nxt, idx;
   logic          found;
   logic [3:0]    snap_row, snap_col, ers_row, ers_col;
   logic [2:0]    snap_color, draw_color;
   logic [OW-1:0] ox, oy;
   logic [SW-1:0] step;
   logic          adv, last, old_hid, snap_hid;
   logic [3:0]    cell_row, cell_col;

   // ---------------- per-channel lanes ----------------
   for (genvar g = 0; g < NC; g++) begin : g_lane
      assign in_row[g] = cursor_row[4*g +: 4];
      assign in_col[g] = cursor_col[4*g +: 4];
      assign in_clr[g] = cursor_color[3*g +: 3];

      assign upd[g]  = (state == FIXUP) && (sel == PW'(g));
      // Another visible cursor sitting on the cell just erased lost its
      // outline; hide it so it is pending and gets redrawn.
      assign kill[g] = (state == FIXUP) && (sel != PW'(g)) &&
                       (shown_row[g] < HID) && (shown_col[g] < HID) &&
                       (shown_row[g] == ers_row) && (shown_col[g] == ers_col);
      assign blink_clr[g] = (state == IDLE) && found && (sel_nxt == PW'(g));

      game_sync_lane #(.GRID_DIM(GRID_DIM)) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_row    (in_row[g]),
         .in_col    (in_col[g]),
         .upd       (upd[g]),
         .upd_row   (snap_row),
         .upd_col   (snap_col),
         .kill      (kill[g]),
         .blink_set (blink_set[g]),
         .blink_clr (blink_clr[g]),
         .pending   (pend[g]),
         .shown_row (shown_row[g]),
         .shown_col (shown_col[g])
      );
   end

   // ---------------- round-robin pick, starting after ptr ----------------
   always_comb begin
      found   = 1'b0;
      sel_nxt = '0;
      idx     = '0;
      for (int k = 0; k < NC; k++) begin
         idx = PW'((int'(ptr) + 1 + k) % NC);
         if (!found && pend[idx]) begin
            found   = 1'b1;
            sel_nxt = idx;
         end
      end
   end

   assign old_hid  = (shown_row[sel_nxt] >= HID) || (shown_col[sel_nxt] >= HID);
   assign snap_hid = (snap_row >= HID) || (snap_col >= HID);

   // ---------------- blink phase ----------------
`ifdef GAME_SYNC_BLINK_EN
   localparam int BW = $clog2(BLINK_PERIOD+1);
   logic [BW-1:0] blink_cnt;
   logic          phase, snap_phase, toggle;

   assign toggle = (blink_cnt == BW'(BLINK_PERIOD-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt  <= '0;
         phase      <= 1'b1;
         snap_phase <= 1'b1;
      end else begin
         blink_cnt <= toggle ? '0 : blink_cnt + 1'b1;
         if (toggle)
            phase <= ~phase;
         // Phase is frozen per service so a toggle mid-walk waits its turn.
         if (state == IDLE && found)
            snap_phase <= phase;
      end
   end

   assign blink_set  = {NC{toggle}};
   assign draw_color = snap_phase ? snap_color : BG_COLOR;
`else
   assign blink_set  = '0;
   assign draw_color = snap_color;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   assign last = (step == SW'(WALK-1));
   assign adv  = write_valid && write_ready;

   always_comb begin
      state_n     = state;
      write_valid = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE:  if (found) state_n = old_hid ? DRAW : ERASE;
         ERASE: begin
            write_valid = 1'b1;
            if (adv && last) state_n = snap_hid ? FIXUP : DRAW;
         end
         DRAW: begin
            write_valid = 1'b1;
            if (adv && last) state_n = FIXUP;
         end
         FIXUP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ---------------- service datapath and perimeter walk ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= PW'(NC-1);
         sel        <= '0;
         snap_row   <= HID;
         snap_col   <= HID;
         snap_color <= '0;
         ers_row    <= HID;
         ers_col    <= HID;
         ox         <= '0;
         oy         <= '0;
         step       <= '0;
      end else begin
         if (state == IDLE && found) begin
            sel        <= sel_nxt;
            snap_row   <= in_row[sel_nxt];
            snap_col   <= in_col[sel_nxt];
            snap_color <= in_clr[sel_nxt];
            ers_row    <= shown_row[sel_nxt];
            ers_col    <= shown_col[sel_nxt];
            ox         <= '0;
            oy         <= '0;
            step       <= '0;
         end else if (adv) begin
            if (last) begin
               ox   <= '0;
               oy   <= '0;
               step <= '0;
            end else begin
               step <= step + 1'b1;
               // Clockwise: top row, right column, bottom row, left column.
               if (oy == '0 && ox != OMAX)
                  ox <= ox + 1'b1;
               else if (ox == OMAX && oy != OMAX)
                  oy <= oy + 1'b1;
               else if (oy == OMAX && ox != '0)
                  ox <= ox - 1'b1;
               else
                  oy <= oy - 1'b1;
            end
         end
         if (state == FIXUP)
            ptr <= sel;
      end
   end

   assign cell_row = (state == ERASE) ? ers_row : snap_row;
   assign cell_col = (state == ERASE) ? ers_col : snap_col;

   assign write_x    = write_valid ? XW'(cell_col) * XW'(CELL_PX) + XW'(ox) : '0;
   assign write_y    = write_valid ? XW'(cell_row) * XW'(CELL_PX) + XW'(oy) : '0;
   assign write_data = !write_valid ? 3'd0 : (state == ERASE) ? BG_COLOR : draw_color;
endmodule

// File: tb/tb_game_sync_multi.sv
module tb_game_sync_multi;
   localparam int N = 2, G = 9, P = 8, XW = 7;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N*4-1:0] cursor_row, cursor_col;
   logic [N*3-1:0] cursor_color;
   logic           write_valid, busy;
   logic           write_ready = 1'b1;
   logic [XW-1:0]  write_x, write_y;
   logic [2:0]     write_data;

   int in_row[N], in_col[N], in_clr[N];
   for (genvar c = 0; c < N; c++) begin : g_drv
      assign cursor_row[4*c +: 4]   = 4'(in_row[c]);
      assign cursor_col[4*c +: 4]   = 4'(in_col[c]);
      assign cursor_color[3*c +: 3] = 3'(in_clr[c]);
   end

   game_sync_multi #(.NUM_CURSORS(N), .GRID_DIM(G), .CELL_PX(P)) dut (
      .clk(clk), .rst_n(rst_n), .cursor_row(cursor_row), .cursor_col(cursor_col),
      .cursor_color(cursor_color), .write_valid(write_valid), .write_ready(write_ready),
      .write_x(write_x), .write_y(write_y), .write_data(write_data), .busy(busy));

   typedef struct packed {logic [6:0] x; logic [6:0] y; logic [2:0] d;} wr_t;
   wr_t obs[$], exp_q[$];
   int  total = 0, bad = 0, rdy_mode = 0;
   bit  mon_en = 0;

   // ---------------- reference model ----------------
   int m_row[N], m_col[N], m_ptr;

   function automatic bit hid(int r, int c);
      return (r >= G) || (c >= G);
   endfunction

   function automatic bit m_pend(int c);
      return ((in_row[c] != m_row[c]) || (in_col[c] != m_col[c])) &&
             !(hid(in_row[c], in_col[c]) && hid(m_row[c], m_col[c]));
   endfunction

   // Outline as 4 sides of P-1 pixels each, clockwise from the top-left corner.
   function automatic void push_walk(int r, int c, int d);
      wr_t w;
      int  ox, oy, s, k;
      for (int i = 0; i < 4*(P-1); i++) begin
         s = i / (P-1);
         k = i % (P-1);
         case (s)
            0: begin ox = k;         oy = 0;         end
            1: begin ox = P-1;       oy = k;         end
            2: begin ox = P-1-k;     oy = P-1;       end
            default: begin ox = 0;   oy = P-1-k;     end
         endcase
         w.x = 7'(c*P + ox);
         w.y = 7'(r*P + oy);
         w.d = 3'(d);
         exp_q.push_back(w);
      end
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         m_row[c] = G;
         m_col[c] = G;
      end
      m_ptr = N-1;
   endfunction

   function automatic void model_serve();
      int s, er, ec, c;
      for (int it = 0; it < 4*N+4; it++) begin
         s = -1;
         for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (s < 0 && m_pend(c)) s = c;
         end
         if (s < 0) break;
         er = m_row[s];
         ec = m_col[s];
         if (!hid(er, ec)) push_walk(er, ec, 0);
         if (!hid(in_row[s], in_col[s])) push_walk(in_row[s], in_col[s], in_clr[s]);
         m_row[s] = in_row[s];
         m_col[s] = in_col[s];
         for (int o = 0; o < N; o++)
            if (o != s && !hid(m_row[o], m_col[o]) && m_row[o] == er && m_col[o] == ec) begin
               m_row[o] = G;
               m_col[o] = G;
            end
         m_ptr = s;
      end
   endfunction

   // ---------------- ready driver and monitor ----------------
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       write_ready = 1'b1;
         1:       write_ready = ~write_ready;
         default: write_ready = 1'($urandom_range(0, 1));
      endcase
   end

   initial begin
      wr_t prev, cur;
      bit  pst;
      pst = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) pst = 0;
         else begin
            cur = '{x: write_x, y: write_y, d: write_data};
            if (pst) begin
               total++;
               if (!write_valid || cur !== prev) begin
                  bad++;
                  $display("FAIL stall_hold got v=%0b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                           write_valid, cur.x, cur.y, cur.d, prev.x, prev.y, prev.d);
               end
            end
            if (write_valid && write_ready) obs.push_back(cur);
            pst  = write_valid && !write_ready;
            prev = cur;
         end
      end
   end

   task automatic wait_idle(input int budget, output bit ok, output int cyc);
      ok = 0;
      for (cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         #1;
         if (cyc > 3 && obs.size() >= exp_q.size() && !busy) begin
            ok = 1;
            break;
         end
      end
      repeat (6) @(negedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input int r, input int col, input int clr);
      in_row[c] = r;
      in_col[c] = col;
      in_clr[c] = clr;
   endtask

   task automatic start_step();
      @(posedge clk);
      #1;
      obs.delete();
      exp_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_ch(0, 4, 4, 5);
      set_ch(1, G, G, 0);
      rst_n = 0;
      repeat (3) @(negedge clk);
      total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", write_valid); end
      total++; if (write_x !== '0)       begin bad++; $display("FAIL rst_x got=%0d want=0", write_x); end
      total++; if (write_y !== '0)       begin bad++; $display("FAIL rst_y got=%0d want=0", write_y); end
      total++; if (write_data !== '0)    begin bad++; $display("FAIL rst_data got=%0d want=0", write_data); end
      total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
   endtask

   task automatic test_first_draw();
      bit ok; int cyc;
      mon_en = 1;
      start_step();
      rst_n = 1;
      model_reset();
      model_serve();
      wait_idle(500, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL first_timeout got=%0d want=%0d", obs.size(), exp_q.size()); end
      total++; if (obs.size() != 28) begin bad++; $display("FAIL first_count got=%0d want=28", obs.size()); end
      if (obs.size() == 28) begin
         total++; if (obs[0]  !== '{x:7'd32, y:7'd32, d:3'd5}) begin bad++; $display("FAIL first_wr0 got=(%0d,%0d,%0d) want=(32,32,5)", obs[0].x, obs[0].y, obs[0].d); end
         total++; if (obs[27] !== '{x:7'd32, y:7'd33, d:3'd5}) begin bad++; $display("FAIL first_wr27 got=(%0d,%0d,%0d) want=(32,33,5)", obs[27].x, obs[27].y, obs[27].d); end
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         total++;
         if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL first_wr[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_busy got=%0b want=0", busy); end
   endtask

   task automatic test_move();
      bit ok; int cyc;
      start_step();
      set_ch(0, 5, 5, 5);
      model_serve();
      @(negedge clk);
      @(negedge clk);
      total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL move_lat1 got=%0b want=0", write_valid); end
      @(negedge clk);
      total++; if (write_valid !== 1'b1) begin bad++; $display("FAIL move_lat2 got=%0b want=1", write_valid); end
      wait_idle(500, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL move_timeout got=%0d want=%0d", obs.size(), exp_q.size()); end
      total++; if (obs.size() != 56) begin bad++; $display("FAIL move_count got=%0d want=56", obs.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         total++;
         if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL move_wr[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d); end
      end
   endtask

   task automatic test_stall();
      bit ok; int cyc;
      start_step();
      set_ch(0, 4, 4, 5);
      model_serve();
      wait_idle(500, ok, cyc);
      start_step();
      rdy_mode = 1;
      set_ch(0, 5, 5, 5);
      model_serve();
      wait_idle(1000, ok, cyc);
      rdy_mode = 0;
      total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=%0d want=%0d", obs.size(), exp_q.size()); end
      total++; if (cyc > 140) begin bad++; $display("FAIL stall_cycles got=%0d want<=140", cyc); end
      total++; if (obs.size() != 56) begin bad++; $display("FAIL stall_count got=%0d want=56", obs.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         total++;
         if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL stall_wr[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d); end
      end
   endtask

   task automatic test_simul();
      bit ok; int cyc;
      start_step();
      rst_n = 0;
      set_ch(0, G, G, 0);
      set_ch(1, G, G, 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (5) @(negedge clk);
      start_step();
      set_ch(0, 1, 1, 3);
      set_ch(1, 6, 7, 6);
      model_serve();
      wait_idle(500, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL simul_timeout got=%0d want=%0d", obs.size(), exp_q.size()); end
      total++; if (obs.size() != 56) begin bad++; $display("FAIL simul_count got=%0d want=56", obs.size()); end
      if (obs.size() == 56) begin
         total++; if (obs[27].x > 15 || obs[27].d !== 3'd3) begin bad++; $display("FAIL simul_ch0_last got=(%0d,%0d) want=ch0 cell colour 3", obs[27].x, obs[27].d); end
         total++; if (obs[28].x < 56 || obs[28].d !== 3'd6) begin bad++; $display("FAIL simul_ch1_first got=(%0d,%0d) want=ch1 cell colour 6", obs[28].x, obs[28].d); end
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         total++;
         if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL simul_wr[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d); end
      end
   endtask

   task automatic test_overlap();
      bit ok; int cyc;
      start_step();
      set_ch(0, 2, 2, 2);
      set_ch(1, 2, 2, 6);
      model_serve();
      wait_idle(800, ok, cyc);
      start_step();
      set_ch(1, 3, 3, 6);
      model_serve();
      wait_idle(800, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL ovl_timeout got=%0d want=%0d", obs.size(), exp_q.size()); end
      total++; if (obs.size() != 84) begin bad++; $display("FAIL ovl_count got=%0d want=84", obs.size()); end
      if (obs.size() == 84) begin
         total++; if (obs[0].d !== 3'd0 || obs[0].x !== 7'd16) begin bad++; $display("FAIL ovl_erase got=(%0d,%0d) want=(16,0)", obs[0].x, obs[0].d); end
         total++; if (obs[83] !== '{x:7'd16, y:7'd17, d:3'd2}) begin bad++; $display("FAIL ovl_redraw got=(%0d,%0d,%0d) want=(16,17,2)", obs[83].x, obs[83].y, obs[83].d); end
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         total++;
         if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL ovl_wr[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d); end
      end
   endtask

   task automatic test_random();
      bit ok; int cyc, o;
      rdy_mode = 2;
      for (int it = 0; it < 24; it++) begin
         start_step();
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 1) == 1)
               set_ch(c, $urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(1, 7));
         if ($urandom_range(0, 3) == 0) begin
            o = $urandom_range(0, N-1);
            set_ch(1-o, in_row[o], in_col[o], $urandom_range(1, 7));
         end
         model_serve();
         wait_idle(2000, ok, cyc);
         total++; if (!ok) begin bad++; $display("FAIL rnd%0d_timeout got=%0d want=%0d", it, obs.size(), exp_q.size()); end
         total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, obs.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_wr[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", it, i, obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d); end
         end
      end
      rdy_mode = 0;
   endtask

   task automatic test_reset_mid();
      bit ok, hit; int cyc;
      start_step();
      set_ch(0, 0, 8, 5);
      set_ch(1, G, G, 0);
      model_serve();
      wait_idle(1000, ok, cyc);
      start_step();
      set_ch(0, 4, 4, 5);
      hit = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (obs.size() >= 10) begin hit = 1; break; end
      end
      total++; if (!hit || busy !== 1'b1) begin bad++; $display("FAIL mid_reach got=%0d writes busy=%0b want>=10 busy=1", obs.size(), busy); end
      rst_n = 0;
      #1;
      total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", write_valid); end
      total++; if (busy !== 1'b0)        begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
      repeat (3) @(negedge clk);
      obs.delete();
      exp_q.delete();
      model_reset();
      model_serve();
      rst_n = 1;
      wait_idle(500, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL mid_timeout got=%0d want=%0d", obs.size(), exp_q.size()); end
      total++; if (obs.size() != 28) begin bad++; $display("FAIL mid_count got=%0d want=28", obs.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         total++;
         if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL mid_wr[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d); end
      end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_move();
      test_stall();
      test_simul();
      test_overlap();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/game_sync_multi.md
Name: game_sync_multi

Overview:
Parametrised successor to the single-cursor game sync block. It tracks NUM_CURSORS cursor positions on a GRID_DIM x GRID_DIM cell board. When any cursor moves, it erases the cursor outline at the old cell and draws it at the new cell, as a stream of pixel writes to the screen buffer. New over the previous generation: multiple cursors with round-robin service, a valid/ready write handshake, hidden positions, and overlap repair. Sits between the game logic (cursor coordinates) and the frame-buffer write port.

Parameters:
NUM_CURSORS, 2, number of independent cursor channels (1..8)
GRID_DIM, 9, cells per board row/column
CELL_PX, 8, cell edge in pixels; outline is the cell perimeter, 4*(CELL_PX-1) pixels
BG_COLOR, 3'd0, colour written when erasing an outline
BLINK_PERIOD, 25000000, cycles per blink phase (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cursor_row  in  NUM_CURSORS*4  per-channel row, channel c at [4c+3:4c]; value >= GRID_DIM means hidden
cursor_col  in  NUM_CURSORS*4  per-channel column, same packing and hidden rule
cursor_color  in  NUM_CURSORS*3  per-channel outline colour
write_valid  out  1  pixel write request
write_ready  in  1  frame buffer accepts the write
write_x  out  $clog2(GRID_DIM*CELL_PX)  pixel column
write_y  out  $clog2(GRID_DIM*CELL_PX)  pixel row
write_data  out  3  pixel colour
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - write_valid=0, write_x=0, write_y=0, write_data=0, busy=0.
  - All shown positions set hidden (row=col=GRID_DIM). Pending flags cleared. Round-robin pointer set to channel NUM_CURSORS-1, so channel 0 has first priority.
  - Blink phase set to on.
- Pending: in every cycle, channel c becomes pending if its input (row,col) differs from its shown (row,col). Hidden-to-hidden changes are ignored.
- FSM states: IDLE, ERASE, DRAW, FIXUP.
  - IDLE: if any channel is pending, pick the first pending channel after the pointer (round-robin). Snapshot that channel's input row, col and colour, then go to ERASE. If the old position is hidden, go directly to DRAW.
  - ERASE: walk the perimeter of the old cell, writing BG_COLOR. Then go to DRAW, or to FIXUP if the new position is hidden.
  - DRAW: walk the perimeter of the snapshot cell, writing the snapshot colour. Then go to FIXUP.
  - FIXUP: one cycle.
    - Shown position := snapshot position; pointer := served channel.
    - Every other visible channel whose shown cell equals the erased cell has its shown position forced to hidden, so it becomes pending and is redrawn.
    - Return to IDLE.
- Perimeter walk (offset ox, oy within the cell):
  - Order: top row ox=0..P-2 at oy=0; right column oy=0..P-2 at ox=P-1; bottom row ox=P-1..1 at oy=P-1; left column oy=P-1..1 at ox=0. Here P=CELL_PX.
  - Exactly 4*(P-1) writes per walk.
  - Pixel coordinates: write_x = col*CELL_PX+ox, write_y = row*CELL_PX+oy.
- Handshake:
  - write_valid rises on the first cycle in ERASE/DRAW.
  - The walk advances only on write_valid && write_ready.
  - While write_valid && !write_ready, write_x, write_y and write_data hold stable.
  - write_valid stays high back-to-back within a walk, including across the ERASE-to-DRAW transition. It drops in FIXUP and IDLE.
- Input changes during service: ignored until FIXUP. If the input differs from the snapshot at that point, the channel is pending again on the next cycle.
- Simultaneous moves: serviced one channel at a time; writes from different channels never interleave.
- Width rule: coordinate products are computed at the write_x width, with no truncation for legal parameters.
- Minimum latency: from input change to first write_valid is 2 cycles (pending detect, then IDLE select).

Optional Feature:
GAME_SYNC_BLINK_EN.
- Defined:
  - A counter toggles the blink phase every BLINK_PERIOD cycles.
  - On each toggle, all visible channels are marked pending.
  - DRAW uses BG_COLOR while the phase is off, and cursor_color while it is on.
  - A toggle during service takes effect for the next service.
- Undefined: no counter; cursors are always drawn in cursor_color.

Test Plan:
All scenarios use GRID_DIM=9, CELL_PX=8, 28 writes per walk.
1. Release reset, ch0=(4,4), colour 3'd5, write_ready=1 → no erase; 28 writes with x,y in 32..39; first write (32,32), last write (32,33); data 5; busy then drops.
2. ch0 moves (4,4)→(5,5) → 28 writes of data 0 on cell x,y 32..39, then 28 writes of data 5 on x,y 40..47; 56 handshakes total.
3. Repeat scenario 2 with write_ready toggling every cycle → outputs stable while stalled; same 56-write sequence; completes in about 112 cycles.
4. ch0 and ch1 change in the same cycle after reset → all 28 ch0 writes precede all 28 ch1 writes; no interleaving.
5. ch0 and ch1 both shown at (2,2); ch1 moves to (3,3) → erase (2,2), draw ch1 at (3,3), then ch0 redrawn at (2,2) with ch0 colour; 84 writes.
6. Assert rst_n=0 mid-ERASE (after write 10) → write_valid=0 immediately, busy=0; after release, ch0 at (4,4) redrawn with 28 draw-only writes.
